// File: rtl/mem_scan_engine.sv
// Memory-sweep sequencer: fill, fill-incrementing, verify-incrementing and checksum over [BASE_ADDR, LAST_ADDR].
// Optional `MEM_SCAN_STRIDE_EN adds a STRIDE input so the sweep can skip addresses.
`timescale 1ns/1ps
module mem_scan_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 26,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    input  logic [DATA_W-1:0] PATTERN,
`ifdef MEM_SCAN_STRIDE_EN
    input  logic [ADDR_W-1:0] STRIDE,
`endif
    output logic [ADDR_W-1:0] ADDR,
    output logic              READ,
    output logic              WRITE,
    output logic [DATA_W-1:0] MEM_DATA_OUT,
    input  logic [DATA_W-1:0] MEM_DATA_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] CHECKSUM,
    output logic [ADDR_W-1:0] ERR_CNT,
    output logic [ADDR_W-1:0] ERR_ADDR,
    output logic              RANGE_ERR
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

    logic [2:0]        state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] exp_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_exp;
    logic              sweep_end;
    logic              range_bad;

    // exp_q tracks PATTERN + access index, so it serves both as fill-inc data and verify reference
    assign nxt_exp   = exp_q + DATA_W'(1);
    assign range_bad = (LAST_ADDR < BASE_ADDR);

`ifdef MEM_SCAN_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W:0]   stride_sum;

    // Extra carry bit keeps the overshoot test honest near the top of the address space
    assign stride_sum = {1'b0, cur} + {1'b0, stride_q};
    assign nxt_addr   = stride_sum[ADDR_W-1:0];
    assign sweep_end  = (cur == last_q) || (stride_sum > {1'b0, last_q});
`else
    assign nxt_addr  = cur + ADDR_W'(1);
    assign sweep_end = (cur == last_q);
`endif

    assign WRITE = (state == S_ISSUE) && !mode_q[1] && !RANGE_ERR;
    assign READ  = (state == S_ISSUE) &&  mode_q[1] && !RANGE_ERR;
    assign BUSY  = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
    assign DONE  = (state == S_FIN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            mode_q       <= '0;
            cur          <= '0;
            last_q       <= '0;
            pat_q        <= '0;
            exp_q        <= '0;
            lat_cnt      <= '0;
            ADDR         <= '0;
            MEM_DATA_OUT <= '0;
            CHECKSUM     <= '0;
            ERR_CNT      <= '0;
            ERR_ADDR     <= '0;
            RANGE_ERR    <= 1'b0;
`ifdef MEM_SCAN_STRIDE_EN
            stride_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        mode_q    <= MODE;
                        last_q    <= LAST_ADDR;
                        pat_q     <= PATTERN;
                        exp_q     <= PATTERN;
                        cur       <= BASE_ADDR;
                        CHECKSUM  <= '0;
                        ERR_CNT   <= '0;
                        ERR_ADDR  <= '0;
                        RANGE_ERR <= range_bad;
`ifdef MEM_SCAN_STRIDE_EN
                        stride_q  <= (STRIDE == '0) ? ADDR_W'(1) : STRIDE;
`endif
                        // A bad range passes through ISSUE with strobes masked, then straight to FIN
                        state     <= S_ISSUE;
                        if (!range_bad) begin
                            ADDR <= BASE_ADDR;
                            if (!MODE[1]) MEM_DATA_OUT <= PATTERN;
                        end
                    end
                end
                S_ISSUE: begin
                    if (RANGE_ERR) begin
                        state <= S_FIN;
                    end else if (!mode_q[1]) begin
                        state <= S_NEXT;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= S_NEXT;
                        if (mode_q[0]) begin
                            CHECKSUM <= CHECKSUM + MEM_DATA_IN;
                        end else if (MEM_DATA_IN != exp_q) begin
                            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ADDR_W'(1);
                            if (ERR_CNT == '0) ERR_ADDR <= cur;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (sweep_end) begin
                        state <= S_FIN;
                    end else begin
                        cur   <= nxt_addr;
                        exp_q <= nxt_exp;
                        ADDR  <= nxt_addr;
                        if (!mode_q[1]) MEM_DATA_OUT <= mode_q[0] ? nxt_exp : pat_q;
                        state <= S_ISSUE;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scan_engine.sv
// Directed bench for mem_scan_engine: one instance at RD_LATENCY=1, one at RD_LATENCY=4, sharing a word memory model.
`timescale 1ns/1ps
module tb_mem_scan_engine;

    localparam int DW = 32;
    localparam int AW = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0, start4 = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base = '0, last = '0;
    logic [DW-1:0] pattern = '0;
`ifdef MEM_SCAN_STRIDE_EN
    logic [AW-1:0] stride = '0;
`endif

    logic [AW-1:0] addr1, errc1, erra1, addr4, errc4, erra4;
    logic          rd1, wr1, busy1, done1, rerr1, rd4, wr4, busy4, done4, rerr4;
    logic [DW-1:0] dout1, din1, csum1, dout4, din4, csum4;

    mem_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .MODE(mode),
        .BASE_ADDR(base), .LAST_ADDR(last), .PATTERN(pattern),
`ifdef MEM_SCAN_STRIDE_EN
        .STRIDE(stride),
`endif
        .ADDR(addr1), .READ(rd1), .WRITE(wr1), .MEM_DATA_OUT(dout1), .MEM_DATA_IN(din1),
        .BUSY(busy1), .DONE(done1), .CHECKSUM(csum1), .ERR_CNT(errc1), .ERR_ADDR(erra1),
        .RANGE_ERR(rerr1)
    );

    mem_scan_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(4)) u_dut4 (
        .CLK(clk), .RST(rst), .START(start4), .MODE(mode),
        .BASE_ADDR(base), .LAST_ADDR(last), .PATTERN(pattern),
`ifdef MEM_SCAN_STRIDE_EN
        .STRIDE(stride),
`endif
        .ADDR(addr4), .READ(rd4), .WRITE(wr4), .MEM_DATA_OUT(dout4), .MEM_DATA_IN(din4),
        .BUSY(busy4), .DONE(done4), .CHECKSUM(csum4), .ERR_CNT(errc4), .ERR_ADDR(erra4),
        .RANGE_ERR(rerr4)
    );

    // Memory model: word index = ADDR[9:0]; read data appears RD_LATENCY edges after the READ edge
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe4 [0:3];
    logic          poke_en = 1'b0;
    logic [9:0]    poke_idx = '0;
    logic [DW-1:0] poke_val = '0;

    assign din1 = pipe1;
    assign din4 = pipe4[3];

    always @(posedge clk) begin
        if (wr1) mem[addr1[9:0]] <= dout1;
        if (poke_en) mem[poke_idx] <= poke_val;
        pipe1    <= rd1 ? mem[addr1[9:0]] : 32'hDEADBEEF;
        pipe4[0] <= rd4 ? mem[addr4[9:0]] : 32'hDEADBEEF;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end

    int   cyc = 0;
    logic clr_cnt = 1'b0;
    int   wr_cnt, rd_cnt, done_cnt, pulse_cnt, first_pulse, last_pulse;
    int   both_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((rd1 && wr1) || (rd4 && wr4)) both_cnt <= both_cnt + 1;
        if (clr_cnt) begin
            wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0;
            pulse_cnt <= 0; first_pulse <= 0; last_pulse <= 0;
        end else begin
            wr_cnt   <= wr_cnt + int'(wr1) + int'(wr4);
            rd_cnt   <= rd_cnt + int'(rd1) + int'(rd4);
            done_cnt <= done_cnt + int'(done1) + int'(done4);
            if (wr1 || rd1 || rd4) begin
                if (pulse_cnt == 0) first_pulse <= cyc;
                last_pulse <= cyc;
                pulse_cnt  <= pulse_cnt + 1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    endtask

    // Launches one sweep and returns the DONE cycle counted from the START edge (period after it = 1).
    // bump >= 0 pulses START at that cycle of the run, and again during FIN; both must be ignored.
    task automatic run(input bit use4, input logic [1:0] m, input logic [AW-1:0] b,
                       input logic [AW-1:0] l, input logic [DW-1:0] p, input int bump,
                       output int lat);
        int t0;
        @(negedge clk);
        mode = m; base = b; last = l; pattern = p; clr_cnt = 1'b1;
        if (use4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0; clr_cnt = 1'b0;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (use4 ? done4 : done1) begin
                lat = cyc - t0 + 1;
                break;
            end
            if (i == bump) begin
                start = 1'b1; mode = ~m; base = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (bump >= 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke(input logic [9:0] idx, input logic [DW-1:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_strobes", {rd1, wr1}, 2'b00);
        check("rst_addr", addr1, '0);
        check("rst_dout", dout1, '0);
        check("rst_results", {csum1, errc1, erra1, rerr1}, '0);
        rst = 1'b0;

        // FILL_INC 16 words -> 'h100..'h10f
        run(1'b0, 2'b01, 26'h1000000, 26'h100000f, 32'h100, -1, lat);
        check("fill_done_cycle", lat, 33);
        check("fill_writes", wr_cnt, 16);
        check("fill_spacing", last_pulse - first_pulse, 30);
        check("fill_busy_after", busy1, 1'b0);
        check("fill_done_once", done_cnt, 1);
        for (int i = 0; i < 16; i++) check($sformatf("fill_mem%0d", i), mem[i], 32'h100 + i);

        // Corrupt 'h01000005 and verify
        poke(10'd5, 32'h0);
        run(1'b0, 2'b10, 26'h1000000, 26'h100000f, 32'h100, -1, lat);
        check("verify_done_cycle", lat, 49);
        check("verify_reads", rd_cnt, 16);
        check("verify_spacing", last_pulse - first_pulse, 45);
        check("verify_errcnt", errc1, 1);
        check("verify_erraddr", erra1, 26'h1000005);

        poke(10'd5, 32'h105);
        run(1'b0, 2'b11, 26'h1000000, 26'h100000f, 32'h0, -1, lat);
        check("csum1_value", csum1, 32'h1078);
        check("csum1_errcnt_cleared", errc1, 0);
        check("csum1_done_cycle", lat, 49);

        run(1'b1, 2'b11, 26'h1000000, 26'h100000f, 32'h0, -1, lat);
        check("csum4_value", csum4, 32'h1078);
        check("csum4_done_cycle", lat, 97);
        check("csum4_spacing", last_pulse - first_pulse, 90);
        check("csum4_reads", rd_cnt, 16);

        // Inverted range: no accesses, DONE two cycles after START
        run(1'b0, 2'b01, 26'h10, 26'h0f, 32'h77, -1, lat);
        check("range_err", rerr1, 1'b1);
        check("range_done_cycle", lat, 2);
        check("range_no_access", rd_cnt + wr_cnt, 0);

        // Single-word range
        run(1'b0, 2'b00, 26'h3ff, 26'h3ff, 32'hABCD, -1, lat);
        check("single_range_err_clr", rerr1, 1'b0);
        check("single_writes", wr_cnt, 1);
        check("single_mem", mem[1023], 32'hABCD);
        check("single_done_cycle", lat, 3);

        // Reset five cycles into a 16-word FILL
        @(negedge clk);
        mode = 2'b00; base = 26'h20; last = 26'h2f; pattern = 32'h55; start = 1'b1; clr_cnt = 1'b1;
        @(negedge clk);
        start = 1'b0; clr_cnt = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_strobes", {rd1, wr1}, 2'b00);
        check("abort_busy", busy1, 1'b0);
        check("abort_writes", wr_cnt, 3);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);

        // Normal restart with ignored START pulses mid-run and in FIN
        run(1'b0, 2'b01, 26'h20, 26'h2f, 32'h200, 3, lat);
        check("restart_done_cycle", lat, 33);
        check("restart_writes", wr_cnt, 16);
        check("restart_mem_first", mem[32], 32'h200);
        check("restart_mem_last", mem[47], 32'h20f);
        check("fin_start_ignored", busy1, 1'b0);

`ifdef MEM_SCAN_STRIDE_EN
        stride = 26'd4;
        run(1'b0, 2'b01, 26'h0, 26'h0e, 32'h0, -1, lat);
        check("stride_writes", wr_cnt, 4);
        check("stride_mem", {mem[0], mem[4], mem[8], mem[12]}, {32'd0, 32'd1, 32'd2, 32'd3});
        check("stride_done_cycle", lat, 9);
        stride = '0;
`endif

        check("never_rd_and_wr", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
